// File: rtl/button_event_queue_if.sv
// Consumer-side bundle for button_event_queue.
//   master : the queue itself (drives the event head and flags)
//   slave  : the game logic (pops events, clears the overflow flag)
// Signals:
//   rd_en          pop request from the consumer
//   event_valid    queue holds at least one event
//   event_code     head event, button index + 1 (0 when empty)
//   count          number of queued events, 0..DEPTH
//   overflow       sticky "a press was discarded" flag
//   clear_overflow synchronous clear of overflow
interface button_event_queue_if #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 3
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              rd_en;
  logic              event_valid;
  logic [CODE_W-1:0] event_code;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              clear_overflow;

  modport master (
    input  rd_en,
    input  clear_overflow,
    output event_valid,
    output event_code,
    output count,
    output overflow
  );

  modport slave (
    output rd_en,
    output clear_overflow,
    input  event_valid,
    input  event_code,
    input  count,
    input  overflow
  );
endinterface

// File: rtl/button_event_queue.sv
// button_event_queue
// Collects one-cycle press pulses from the five button debouncers and hands
// them to the game logic one at a time as encoded events (index + 1).
// Each button owns a pending bit so simultaneous presses are not lost; the
// pending bits drain by fixed priority (up first) into a small FWFT FIFO.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   btn_pulse  press pulses: 0 up, 1 down, 2 left, 3 right, 4 centre
//   bus        consumer interface (master side), see button_event_queue_if
module button_event_queue #(
  parameter int NUM_BTN = 5,
  parameter int DEPTH   = 4,
  parameter int CODE_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_pulse,
  button_event_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_BTN-1:0] pending;
  logic [CODE_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic               pop;
  logic               push_ok;
  logic [NUM_BTN-1:0] grant;
  logic               push;
  logic [CODE_W-1:0]  push_code;
  logic               overflow_set;

  // A full FIFO can still accept a push when the head leaves in the same
  // cycle. The grant isolates the lowest set pending bit (x & -x).
  always_comb begin
    pop          = bus.rd_en && (count != '0);
    push_ok      = (count != CNT_W'(DEPTH)) || pop;
    grant        = pending & (~pending + NUM_BTN'(1)) & {NUM_BTN{push_ok}};
    push         = |grant;
    overflow_set = |(btn_pulse & pending & ~grant);
    push_code    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grant[i]) push_code = CODE_W'(i + 1);
    end
  end

  // Pending bits, FIFO storage, pointers and count. A granted bit that is
  // pressed again in the same cycle is simply re-armed by the new pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pending <= (pending & ~grant) | btn_pulse;
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a fresh discard in the same cycle beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   overflow <= 1'b0;
    else if (overflow_set)       overflow <= 1'b1;
    else if (bus.clear_overflow) overflow <= 1'b0;
  end

  assign bus.event_valid = (count != '0);
  assign bus.event_code  = bus.event_valid ? mem[rd_ptr] : '0;
  assign bus.count       = count;
  assign bus.overflow    = overflow;
endmodule

// File: tb/tb_button_event_queue.sv
// Directed self-checking bench for button_event_queue.
module tb_button_event_queue;
  logic       clk;
  logic       reset;
  logic [4:0] btn_pulse;

  int pass_cnt;
  int total_cnt;

  button_event_queue_if #(.DEPTH(4), .CODE_W(3)) bus ();

  button_event_queue #(.NUM_BTN(5), .DEPTH(4), .CODE_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts every call, counts passes, reports failures.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] code,
                           input logic [2:0] cnt, input logic ovf);
    check_output({tag, ".valid"}, 32'(bus.event_valid), 32'(v));
    check_output({tag, ".code"}, 32'(bus.event_code), 32'(code));
    check_output({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check_output({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf));
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    btn_pulse = '0;
    bus.rd_en = 1'b0;
    bus.clear_overflow = 1'b0;
    #3;
    check_all("reset", 1'b0, 3'd0, 3'd0, 1'b0);
    tick();
    reset = 1'b0;

    // Single press of left
    btn_pulse = 5'b00100;
    tick();
    btn_pulse = '0;
    check_all("single.c1", 1'b0, 3'd0, 3'd0, 1'b0);
    tick();
    check_all("single.c2", 1'b1, 3'd3, 3'd1, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_all("single.pop", 1'b0, 3'd0, 3'd0, 1'b0);

    // Simultaneous up, right, centre
    btn_pulse = 5'b11001;
    tick();
    btn_pulse = '0;
    check_output("simul.cnt0", 32'(bus.count), 32'd0);
    tick();
    check_output("simul.cnt1", 32'(bus.count), 32'd1);
    tick();
    check_output("simul.cnt2", 32'(bus.count), 32'd2);
    tick();
    check_output("simul.cnt3", 32'(bus.count), 32'd3);
    tick();
    check_all("simul.settled", 1'b1, 3'd1, 3'd3, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    check_output("simul.pop1", 32'(bus.event_code), 32'd4);
    tick();
    check_output("simul.pop2", 32'(bus.event_code), 32'd5);
    tick();
    bus.rd_en = 1'b0;
    check_all("simul.empty", 1'b0, 3'd0, 3'd0, 1'b0);

    // Re-press of down in consecutive cycles
    btn_pulse = 5'b00010;
    tick();
    tick();
    btn_pulse = '0;
    check_output("repress.ovf_mid", 32'(bus.overflow), 32'd0);
    tick();
    check_all("repress", 1'b1, 3'd2, 3'd2, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    check_all("repress.pop1", 1'b1, 3'd2, 3'd1, 1'b0);
    tick();
    bus.rd_en = 1'b0;
    check_all("repress.pop2", 1'b0, 3'd0, 3'd0, 1'b0);

    // Fill with 2,1,3,5
    btn_pulse = 5'b00010; tick();
    btn_pulse = 5'b00001; tick();
    btn_pulse = 5'b00100; tick();
    btn_pulse = 5'b10000; tick();
    btn_pulse = '0;       tick();
    check_all("full", 1'b1, 3'd2, 3'd4, 1'b0);
    // Right waits while full
    btn_pulse = 5'b01000; tick();
    btn_pulse = '0;       tick();
    check_all("full.wait", 1'b1, 3'd2, 3'd4, 1'b0);
    // Pop at full grants right in the same cycle
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_all("full.poppush", 1'b1, 3'd1, 3'd4, 1'b0);

    // Overflow: up waits, then up again
    btn_pulse = 5'b00001; tick();
    check_output("ovf.first", 32'(bus.overflow), 32'd0);
    tick();
    btn_pulse = '0;
    check_output("ovf.set", 32'(bus.overflow), 32'd1);
    check_output("ovf.count", 32'(bus.count), 32'd4);
    bus.clear_overflow = 1'b1;
    tick();
    check_output("ovf.clear", 32'(bus.overflow), 32'd0);
    btn_pulse = 5'b00001;
    tick();
    bus.clear_overflow = 1'b0;
    btn_pulse = '0;
    check_output("ovf.setwins", 32'(bus.overflow), 32'd1);

    // Contents 1,3,5,4 with up pending; pop 1 (up pushed), pop 3
    bus.rd_en = 1'b1;
    tick();
    check_all("wrap.pop1", 1'b1, 3'd3, 3'd4, 1'b1);
    tick();
    bus.rd_en = 1'b0;
    check_all("wrap.pop2", 1'b1, 3'd5, 3'd3, 1'b1);

    // Reset mid-operation with a press in pending
    btn_pulse = 5'b00100;
    tick();
    btn_pulse = 5'b00010;
    #3;
    reset = 1'b1;
    #1;
    check_all("midreset", 1'b0, 3'd0, 3'd0, 1'b0);
    tick();
    reset = 1'b0;
    btn_pulse = '0;
    tick();
    tick();
    check_all("postreset.idle", 1'b0, 3'd0, 3'd0, 1'b0);
    btn_pulse = 5'b00100;
    tick();
    btn_pulse = '0;
    tick();
    check_all("postreset.single", 1'b1, 3'd3, 3'd1, 1'b0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_all("postreset.pop", 1'b0, 3'd0, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
